vending_controller: RTL and testbench

Top-level sequencer of the micro vending machine. It collects debounced button and coin pulses, runs the purchase state machine, and drives the one-hot `state` bus and the money and goods fields consumed by the 8-digit seven-segment display driver. All money values are binary integers in yuan, 0–99, so the display can split each into two decimal digits.

---
 rtl/vending_pkg.sv | 21 ++
 rtl/vending_timer.sv | 25 ++
 rtl/vending_controller.sv | 203 ++++++++++++++++++++
 tb/tb_vending_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: state encodings, coin values and BCD helper
// shared by the micro vending machine blocks.
package vending_pkg;

  localparam logic [6:0] ST_IDLE   = 7'b0000001;
  localparam logic [6:0] ST_SEL_A  = 7'b0000010;
  localparam logic [6:0] ST_SEL_B  = 7'b0000100;
  localparam logic [6:0] ST_PAY    = 7'b0001000;
  localparam logic [6:0] ST_DISP   = 7'b0010000;
  localparam logic [6:0] ST_CHANGE = 7'b0100000;

  localparam logic [7:0] COIN_1_VAL  = 8'd1;
  localparam logic [7:0] COIN_5_VAL  = 8'd5;
  localparam logic [7:0] COIN_10_VAL = 8'd10;
  localparam logic [7:0] MAX_MONEY   = 8'd99;

  function automatic logic [7:0] to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

endpackage

// File: rtl/vending_timer.sv
// vending_timer: 32-bit reloadable down counter shared
// by the dwell and payment-timeout functions.
module vending_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 32'd1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/vending_controller.sv
// vending_controller: purchase sequencer of the micro
// vending machine; drives state, money and goods fields.
module vending_controller
  import vending_pkg::*;
#(
  parameter logic [7:0]  PRICE_A     = 8'd6,
  parameter logic [7:0]  PRICE_B     = 8'd9,
  parameter logic [31:0] HOLD_CYC    = 32'd200_000_000,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       btn_start,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_confirm,
  input  logic       btn_cancel,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       coin_10,
  output logic [6:0] state,
  output logic [7:0] need_money,
  output logic [7:0] input_money,
  output logic [7:0] change_money,
  output logic [3:0] goods_one_high,
  output logic [3:0] goods_one_low,
  output logic [3:0] goods_two_high,
  output logic [3:0] goods_two_low,
  output logic [1:0] goods_one_num,
  output logic [1:0] goods_two_num,
  output logic       dispense,
  output logic       coin_reject
);

  localparam logic [7:0] BCD_A = to_bcd(PRICE_A);
  localparam logic [7:0] BCD_B = to_bcd(PRICE_B);

  logic [6:0] state_q, state_d;
  logic [7:0] need_q, need_d;
  logic [7:0] input_q, input_d;
  logic [7:0] change_q, change_d;
  logic [1:0] num1_q, num1_d;
  logic [1:0] num2_q, num2_d;
  logic [7:0] bcd_a_q, bcd_a_d;
  logic [7:0] bcd_b_q, bcd_b_d;
  logic       disp_q, disp_d;
  logic       rej_q, rej_d;

  logic [7:0]  coin_sum;
  logic [7:0]  pay_sum;
  logic [7:0]  acc_total;
  logic [7:0]  order_total;
  logic        coin_any;
  logic        coin_ok;
  logic        tmr_load;
  logic [31:0] tmr_val;
  logic        tmr_expired;

  assign coin_any = coin_1 | coin_5 | coin_10;
  assign coin_sum = (coin_1  ? COIN_1_VAL  : 8'd0)
                  + (coin_5  ? COIN_5_VAL  : 8'd0)
                  + (coin_10 ? COIN_10_VAL : 8'd0);
  assign pay_sum   = input_q + coin_sum;
  assign coin_ok   = (pay_sum <= MAX_MONEY);
  assign acc_total = coin_ok ? pay_sum : input_q;
  assign order_total = ({6'd0, num1_q} * PRICE_A)
                     + ({6'd0, num2_q} * PRICE_B);

  always_comb begin
    state_d  = state_q;
    need_d   = need_q;
    input_d  = input_q;
    change_d = change_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    bcd_a_d  = bcd_a_q;
    bcd_b_d  = bcd_b_q;
    disp_d   = 1'b0;
    rej_d    = 1'b0;
    unique case (1'b1)
      state_q[0]: begin
        if (btn_start) begin
          state_d = ST_SEL_A;
          bcd_a_d = BCD_A;
          bcd_b_d = BCD_B;
        end
      end
      state_q[1], state_q[2]: begin
        if (btn_cancel) begin
          state_d = ST_IDLE;
          need_d  = '0;
          num1_d  = '0;
          num2_d  = '0;
          bcd_a_d = '0;
          bcd_b_d = '0;
        end else if (btn_confirm) begin
          need_d = order_total;
          if (order_total != '0) begin
            state_d = ST_PAY;
            input_d = '0;
          end
        end else if (btn_next) begin
          state_d = state_q[1] ? ST_SEL_B : ST_SEL_A;
        end else if (btn_inc) begin
          if (state_q[1]) num1_d = num1_q + 2'd1;
          else            num2_d = num2_q + 2'd1;
        end
      end
      state_q[3]: begin
        // a cycle's coins are taken or refused as a whole
        if (coin_any) begin
          if (coin_ok) input_d = pay_sum;
          else         rej_d   = 1'b1;
        end
        if (btn_cancel) begin
          state_d  = ST_CHANGE;
          change_d = acc_total;
          need_d   = '0;
        end else if (coin_any && coin_ok && pay_sum >= need_q) begin
          state_d  = ST_DISP;
          change_d = pay_sum - need_q;
          disp_d   = 1'b1;
        end else if (!coin_any && tmr_expired) begin
          state_d  = ST_CHANGE;
          change_d = input_q;
          need_d   = '0;
        end
      end
      state_q[4]: begin
        if (tmr_expired) state_d = ST_CHANGE;
      end
      state_q[5]: begin
        if (tmr_expired) begin
          state_d  = ST_IDLE;
          need_d   = '0;
          input_d  = '0;
          change_d = '0;
          num1_d   = '0;
          num2_d   = '0;
          bcd_a_d  = '0;
          bcd_b_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // reload on each state entry and on every coin seen in PAY
  assign tmr_load = (state_d != state_q)
                  || ((state_q == ST_PAY) && coin_any);
  assign tmr_val  = ((state_d == ST_DISP) || (state_d == ST_CHANGE))
                  ? (HOLD_CYC - 32'd1) : (TIMEOUT_CYC - 32'd1);

  vending_timer u_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      need_q   <= '0;
      input_q  <= '0;
      change_q <= '0;
      num1_q   <= '0;
      num2_q   <= '0;
      bcd_a_q  <= '0;
      bcd_b_q  <= '0;
      disp_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      need_q   <= need_d;
      input_q  <= input_d;
      change_q <= change_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
      bcd_a_q  <= bcd_a_d;
      bcd_b_q  <= bcd_b_d;
      disp_q   <= disp_d;
      rej_q    <= rej_d;
    end
  end

  assign state          = state_q;
  assign need_money     = need_q;
  assign input_money    = input_q;
  assign change_money   = change_q;
  assign goods_one_high = bcd_a_q[7:4];
  assign goods_one_low  = bcd_a_q[3:0];
  assign goods_two_high = bcd_b_q[7:4];
  assign goods_two_low  = bcd_b_q[3:0];
  assign goods_one_num  = num1_q;
  assign goods_two_num  = num2_q;
  assign dispense       = disp_q;
  assign coin_reject    = rej_q;

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed scenarios plus random
// stimulus checked against a behavioural purchase model.
module tb_vending_controller;

  localparam logic [7:0] PA = 8'd13;
  localparam logic [7:0] PB = 8'd20;
  localparam int HOLD = 20;
  localparam int TOUT = 50;

  localparam int S_IDLE = 0;
  localparam int S_SELA = 1;
  localparam int S_SELB = 2;
  localparam int S_PAY  = 3;
  localparam int S_DISP = 4;
  localparam int S_CHG  = 5;

  localparam logic [4:0] B_START = 5'b10000;
  localparam logic [4:0] B_NEXT  = 5'b01000;
  localparam logic [4:0] B_INC   = 5'b00100;
  localparam logic [4:0] B_CONF  = 5'b00010;
  localparam logic [4:0] B_CAN   = 5'b00001;
  localparam logic [2:0] C1  = 3'b001;
  localparam logic [2:0] C5  = 3'b010;
  localparam logic [2:0] C10 = 3'b100;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic btn_start = 0, btn_next = 0, btn_inc = 0;
  logic btn_confirm = 0, btn_cancel = 0;
  logic coin_1 = 0, coin_5 = 0, coin_10 = 0;
  logic [6:0] state;
  logic [7:0] need_money, input_money, change_money;
  logic [3:0] goods_one_high, goods_one_low;
  logic [3:0] goods_two_high, goods_two_low;
  logic [1:0] goods_one_num, goods_two_num;
  logic dispense, coin_reject;

  vending_controller #(
    .PRICE_A(PA), .PRICE_B(PB),
    .HOLD_CYC(32'd20), .TIMEOUT_CYC(32'd50)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .btn_start(btn_start), .btn_next(btn_next),
    .btn_inc(btn_inc), .btn_confirm(btn_confirm),
    .btn_cancel(btn_cancel),
    .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
    .state(state), .need_money(need_money),
    .input_money(input_money), .change_money(change_money),
    .goods_one_high(goods_one_high), .goods_one_low(goods_one_low),
    .goods_two_high(goods_two_high), .goods_two_low(goods_two_low),
    .goods_one_num(goods_one_num), .goods_two_num(goods_two_num),
    .dispense(dispense), .coin_reject(coin_reject)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  int m_st, m_need, m_in, m_chg, m_n1, m_n2, m_age;
  bit m_goods, m_disp, m_rej;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_need = 0; m_in = 0; m_chg = 0;
    m_n1 = 0; m_n2 = 0; m_age = 0;
    m_goods = 0; m_disp = 0; m_rej = 0;
  endtask

  task automatic model_step(input logic [4:0] b, input logic [2:0] c);
    int sum, tot;
    bit any;
    sum = (c[0] ? 1 : 0) + (c[1] ? 5 : 0) + (c[2] ? 10 : 0);
    any = (c != 3'b000);
    m_disp = 0;
    m_rej = 0;
    case (m_st)
      S_IDLE: if (b[4]) begin m_st = S_SELA; m_goods = 1; end
      S_SELA, S_SELB: begin
        if (b[0]) begin
          model_reset();
        end else if (b[1]) begin
          m_need = m_n1 * PA + m_n2 * PB;
          if (m_need > 0) begin m_st = S_PAY; m_in = 0; m_age = 0; end
        end else if (b[3]) begin
          m_st = (m_st == S_SELA) ? S_SELB : S_SELA;
        end else if (b[2]) begin
          if (m_st == S_SELA) m_n1 = (m_n1 + 1) % 4;
          else                m_n2 = (m_n2 + 1) % 4;
        end
      end
      S_PAY: begin
        tot = m_in;
        if (any) begin
          m_age = 0;
          if (m_in + sum > 99) m_rej = 1;
          else tot = m_in + sum;
        end else begin
          m_age++;
        end
        m_in = tot;
        if (b[0]) begin
          m_st = S_CHG; m_chg = tot; m_need = 0; m_age = 0;
        end else if (any && !m_rej && tot >= m_need) begin
          m_st = S_DISP; m_chg = tot - m_need; m_disp = 1; m_age = 0;
        end else if (m_age == TOUT) begin
          m_st = S_CHG; m_chg = tot; m_need = 0; m_age = 0;
        end
      end
      S_DISP: begin
        m_age++;
        if (m_age == HOLD) begin m_st = S_CHG; m_age = 0; end
      end
      default: begin
        m_age++;
        if (m_age == HOLD) model_reset();
      end
    endcase
  endtask

  task automatic compare_all();
    int g;
    g = m_goods ? ((PA / 10) << 12) | ((PA % 10) << 8)
                | ((PB / 10) << 4) | (PB % 10) : 0;
    chk("state", 32'(state), 32'(1 << m_st));
    chk("need", 32'(need_money), 32'(m_need));
    chk("input", 32'(input_money), 32'(m_in));
    chk("change", 32'(change_money), 32'(m_chg));
    chk("goods", 32'({goods_one_high, goods_one_low,
                      goods_two_high, goods_two_low}), 32'(g));
    chk("nums", 32'({goods_one_num, goods_two_num}),
        32'(m_n1 * 4 + m_n2));
    chk("pulses", 32'({dispense, coin_reject}),
        32'(m_disp * 2 + m_rej));
  endtask

  task automatic reset_vals(input string tag);
    chk(tag, 32'({state, need_money, input_money, change_money}),
        32'({7'b0000001, 24'd0}));
    chk(tag, 32'({goods_one_high, goods_one_low, goods_two_high,
                  goods_two_low, goods_one_num, goods_two_num,
                  dispense, coin_reject}), 32'd0);
  endtask

  task automatic cyc(input logic [4:0] b, input logic [2:0] c);
    {btn_start, btn_next, btn_inc, btn_confirm, btn_cancel} = b;
    {coin_10, coin_5, coin_1} = c;
    @(posedge sys_clk);
    model_step(b, c);
    #1;
    compare_all();
    @(negedge sys_clk);
    {btn_start, btn_next, btn_inc, btn_confirm, btn_cancel} = '0;
    {coin_10, coin_5, coin_1} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0);
  endtask

  initial begin
    logic [4:0] b;
    logic [2:0] c;
    bit quiet;
    model_reset();
    repeat (2) @(negedge sys_clk);
    reset_vals("reset");
    sys_rst_n = 1'b1;

    // normal purchase: 1xA + 2xB
    cyc(B_START, '0); cyc(B_INC, '0); cyc(B_NEXT, '0);
    cyc(B_INC, '0); cyc(B_INC, '0); cyc(B_CONF, '0);
    chk("need_total", 32'(need_money), 32'(PA + 2 * PB));
    chk("in_pay", 32'(state), 32'h08);
    repeat (5) cyc('0, C10);
    cyc('0, C5);
    chk("dispensed", 32'({state, change_money}),
        32'({7'b0010000, 8'(55 - PA - 2 * PB)}));
    idle(2 * HOLD);
    chk("back_idle", 32'({state, change_money}), 32'h0100);

    // empty order, then quantity wrap
    cyc(B_START, '0); cyc(B_CONF, '0);
    chk("empty_order", 32'(state), 32'h02);
    repeat (3) cyc(B_INC, '0);
    chk("num_three", 32'(goods_one_num), 32'd3);
    cyc(B_INC, '0);
    chk("num_wrap", 32'(goods_one_num), 32'd0);
    cyc(B_CAN, '0);

    // saturation at 99
    cyc(B_START, '0); repeat (3) cyc(B_INC, '0);
    cyc(B_NEXT, '0); repeat (3) cyc(B_INC, '0);
    cyc(B_CONF, '0);
    repeat (9) cyc('0, C10);
    chk("sat_90", 32'(input_money), 32'd90);
    cyc('0, C10);
    chk("sat_reject", 32'({coin_reject, input_money}), 32'h15A);
    cyc('0, C5); cyc('0, C1 | C5 | C10);
    repeat (4) cyc('0, C1);
    idle(2 * HOLD);

    // all three coins in one cycle from zero
    cyc(B_START, '0); cyc(B_INC, '0); cyc(B_CONF, '0);
    cyc('0, C1 | C5 | C10);
    chk("combo_16", 32'(input_money), 32'd16);
    idle(2 * HOLD);

    // cancel with a same-cycle coin
    cyc(B_START, '0); cyc(B_INC, '0); cyc(B_CONF, '0);
    cyc('0, C5); cyc('0, C1); cyc('0, C1);
    cyc(B_CAN, C5);
    chk("cancel_refund", 32'({state, change_money, dispense}),
        32'({7'b0100000, 8'd12, 1'b0}));
    idle(HOLD);

    // payment timeout
    cyc(B_START, '0); cyc(B_INC, '0); cyc(B_NEXT, '0);
    cyc(B_INC, '0); cyc(B_CONF, '0); cyc('0, C10);
    idle(TOUT - 1);
    chk("not_yet_timeout", 32'(state), 32'h08);
    idle(1);
    chk("timeout_refund", 32'({state, change_money}),
        32'({7'b0100000, 8'd10}));
    idle(HOLD);

    // asynchronous reset in the middle of DISPENSE
    cyc(B_START, '0); cyc(B_INC, '0); cyc(B_CONF, '0);
    cyc('0, C10); cyc('0, C5); idle(3);
    chk("pre_rst_disp", 32'(state), 32'h10);
    #2 sys_rst_n = 1'b0;
    #1 reset_vals("async_rst");
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 250) % 3 == 2);
      b = '0;
      if ($urandom_range(3) == 0)  b[4] = 1'b1;
      if ($urandom_range(9) == 0)  b[3] = 1'b1;
      if ($urandom_range(4) == 0)  b[2] = 1'b1;
      if ($urandom_range(11) == 0) b[1] = 1'b1;
      if ($urandom_range(59) == 0) b[0] = 1'b1;
      c = '0;
      for (int k = 0; k < 3; k++) begin
        if (quiet) c[k] = ($urandom_range(299) == 0);
        else       c[k] = ($urandom_range(4) == 0);
      end
      cyc(b, c);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
